multi_precision_add_sequencer: RTL and testbench
================================================

// Module: multi_precision_add_sequencer
// PURPOSE
//  Multi-cycle controller that computes an N-bit add using one S-bit adder slice, one slice per cycle.
//  Processes LSB slice first and chains the carry through a register; trades latency for adder area.
//  Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
//  One operation in flight at a time.
// PARAMETERS
//  N  128  total operand/result width in bits; must be a multiple of S.
//  S  32   adder slice width in bits; K = N/S slices, K >= 1.
// PORTS
//  clk        in   1  clock; all state updates on rising edge.
//  rst        in   1  synchronous, active-high reset.
//  in_valid   in   1  operand request.
//  in_ready   out  1  accepts operands; equals (state==IDLE) & ~rst.
//  a          in   N  operand A, sampled on in handshake.
//  b          in   N  operand B, sampled on in handshake.
//  ci         in   1  carry in, sampled on in handshake.
//  out_valid  out  1  result available; high in DONE.
//  out_ready  in   1  consumer accepts result.
//  c          out  N  sum; registered.
//  co         out  1  carry out of MSB slice; registered.
// BEHAVIOUR
//  Reset:
//   - State goes to IDLE; out_valid=0, c=0, co=0, carry reg=0, slice cnt=0.
//   - in_ready=0 while rst is high.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: on in_valid & in_ready, latch a/b, set carry reg=ci and cnt=0, go to RUN.
//   - RUN: slice[cnt] = a[cnt*S +: S] + b[cnt*S +: S] + carry.
//     - Write the sum into c[cnt*S +: S] and the slice carry-out into the carry reg.
//     - cnt += 1. When cnt == K-1, also load co from the slice carry-out and go to DONE.
//   - DONE: out_valid=1. On out_ready, go to IDLE; c and co hold their values until the next accept.
//  Latency and throughput:
//   - Accept in cycle 0, RUN in cycles 1..K, out_valid first high in cycle K+1.
//   - With out_ready=1, next accept is no earlier than cycle K+2 (1 op per K+2 cycles).
//  Backpressure: in DONE with out_ready=0, out_valid, c and co stay stable indefinitely.
//  in_valid outside IDLE: ignored; no second operand set is queued.
//  Wrap-around: the result is modulo 2^N; overflow is reported only through co.
//  K==1: RUN lasts one cycle; the same rules apply.
//  Reset mid-operation (any state): the operation is aborted with no output.
//   - out_valid=0 in the cycle after rst is sampled.
// CONFIGURATION
//  Macro MPADD_SUB_EN:
//   - Defined: extra input port sub (1 bit), sampled on in handshake.
//     - sub=1: latch ~b and force carry reg=1, so c = a-b mod 2^N and ci is ignored.
//     - sub=1: co = 1 means no borrow (a >= b unsigned).
//   - Undefined: no sub port; add only.
// STRUCTURE
//  Package mpadd_pkg:
//   - typedef enum logic [1:0] {IDLE, RUN, DONE} mpadd_state_t.
//   - function num_slices(N, S) plus an elaboration check that N % S == 0.
//  Sub-module: one StructuralCarrySelectAdd instance with N=S, as the combinational slice adder
//  (a slice, b slice, carry reg -> sum slice, slice carry-out).
//  Remaining logic: operand registers, cnt of $clog2(K) bits (minimum 1), carry reg, result reg, FSM.
// TESTING  (N=128, S=32, K=4)
//  1. a=2^128-1, b=1, ci=0 -> c=0, co=1; out_valid first high 5 cycles after the accept cycle.
//  2. a=0x0000_0000_FFFF_FFFF, b=1, ci=0 -> c=0x1_0000_0000, co=0 (carry crosses a slice boundary).
//  3. Result ready, out_ready=0 for 10 cycles, in_valid=1 throughout
//     -> out_valid=1 and c/co constant; in_ready=0; no accept until out_ready.
//  4. rst pulsed during RUN cycle 2 -> out_valid=0, c=0; in_ready=1 the cycle after rst drops;
//     no result ever appears for the aborted op.
//  5. Back-to-back random ops with in_valid=out_ready=1 -> accepts exactly every 6 cycles;
//     every result matches a+b+ci mod 2^128 with the correct co.
//  6. MPADD_SUB_EN: a=5, b=7, sub=1 -> c=2^128-2, co=0. a=7, b=5, sub=1 -> c=2, co=1.

Source files
------------

// File: rtl/multi_precision_add_sequencer_pkg.sv
// Shared state encoding and sizing helpers for the slice-serial adder sequencer.
// Slice count and counter width are derived here so every file agrees on them.
package mpadd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mpadd_state_t;

    function automatic int num_slices(input int n, input int s);
        return n / s;
    endfunction

    // A single-slice build still needs a one-bit counter.
    function automatic int cnt_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/multi_precision_add_sequencer_if.sv
// Operand/result handshake bundle for the slice-serial adder; slave side is the sequencer.
// With MPADD_SUB_EN defined the producer also supplies a subtract request bit.
interface multi_precision_add_sequencer_if #(parameter int N = 128);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;
`ifdef MPADD_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic         co;

    modport master (
`ifdef MPADD_SUB_EN
        output sub,
`endif
        output in_valid, a, b, ci, out_ready,
        input  in_ready, out_valid, c, co
    );

    modport slave (
`ifdef MPADD_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, ci, out_ready,
        output in_ready, out_valid, c, co
    );

endinterface

// File: rtl/multi_precision_add_sequencer_csa.sv
// Combinational carry-select adder: low half ripples, high half is precomputed for both carries.
// Zero latency; no flow control.
module StructuralCarrySelectAdd #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    if (N < 2) begin : g_ripple
        assign {co, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
    end else begin : g_csel
        localparam int LO = N / 2;
        localparam int HI = N - LO;

        logic [LO:0] lo_sum;
        logic [HI:0] hi_c0;
        logic [HI:0] hi_c1;

        assign lo_sum = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + {{LO{1'b0}}, ci};
        assign hi_c0  = {1'b0, a[N-1:LO]} + {1'b0, b[N-1:LO]};
        assign hi_c1  = {1'b0, a[N-1:LO]} + {1'b0, b[N-1:LO]} + {{HI{1'b0}}, 1'b1};

        // The low half's carry-out picks which precomputed upper half is real.
        assign {co, s} = lo_sum[LO] ? {hi_c1, lo_sum[LO-1:0]} : {hi_c0, lo_sum[LO-1:0]};
    end

endmodule

// File: rtl/multi_precision_add_sequencer.sv
// N-bit add over one S-bit slice per cycle, LSB first; result valid K+1 cycles after accept,
// held stable under out_ready backpressure. MPADD_SUB_EN adds a subtract (a - b) request.
module multi_precision_add_sequencer
    import mpadd_pkg::*;
#(
    parameter int N = 128,
    parameter int S = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    multi_precision_add_sequencer_if.slave bus
);

    localparam int K  = num_slices(N, S);
    localparam int CW = cnt_width(K);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    if (S < 1 || N < S || (N % S) != 0) begin : g_bad_cfg
        $error("multi_precision_add_sequencer: N must be a positive multiple of S");
    end

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          carry;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [N-1:0]  c_q;
    logic          co_q;
    logic [S-1:0]  a_s;
    logic [S-1:0]  b_s;
    logic [S-1:0]  sum_s;
    logic          cout_s;
    logic          last;
    logic          sub_op;

`ifdef MPADD_SUB_EN
    assign sub_op = bus.sub;
`else
    assign sub_op = 1'b0;
`endif

    always_comb begin
        a_s = '0;
        b_s = '0;
        for (int k = 0; k < K; k++) begin
            if (cnt == CW'(k)) begin
                a_s = a_q[k*S +: S];
                b_s = b_q[k*S +: S];
            end
        end
    end

    assign last = (cnt == CW'(K - 1));

    StructuralCarrySelectAdd #(.N(S)) u_slice (
        .a  (a_s),
        .b  (b_s),
        .ci (carry),
        .s  (sum_s),
        .co (cout_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            co_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        // Subtract is a + ~b + 1, so the forced carry replaces ci.
                        a_q   <= bus.a;
                        b_q   <= sub_op ? ~bus.b : bus.b;
                        carry <= sub_op | bus.ci;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < K; k++) begin
                        if (cnt == CW'(k)) begin
                            c_q[k*S +: S] <= sum_s;
                        end
                    end
                    carry <= cout_s;
                    cnt   <= last ? '0 : cnt + CW'(1);
                    if (last) begin
                        co_q  <= cout_s;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE) & ~rst;
    assign bus.out_valid = (state == ST_DONE);
    assign bus.c         = c_q;
    assign bus.co        = co_q;

endmodule

// File: tb/tb_multi_precision_add_sequencer.sv
// Directed bench for the slice-serial adder with a cycle-level arithmetic reference model.
module tb_multi_precision_add_sequencer;

    localparam int N = 128;
    localparam int S = 32;
    localparam int K = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multi_precision_add_sequencer_if #(.N(N)) bus ();

    multi_precision_add_sequencer #(.N(N), .S(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: an accepted op yields {co,c} = a + b + ci (or a - b) exactly K+1
    // cycles later and stays visible until consumed; reset drops everything and clears c/co.
    bit           mdl_on = 1'b0;
    bit           m_busy;
    bit           m_done;
    bit           m_known;
    int           m_cnt;
    logic [N:0]   m_res;
    logic [N-1:0] m_b;
    logic         m_cin;
    logic         m_sub;

    always @(negedge clk) begin
        if (mdl_on) begin
            check("m_in_ready", bus.in_ready, !m_busy && !m_done && !rst);
            check("m_out_valid", bus.out_valid, m_done);
            if (m_known) check("m_result", {bus.co, bus.c}, m_res);
        end
        if (rst) begin
            mdl_on  = 1'b1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_known = 1'b1;
            m_res   = '0;
        end else if (mdl_on) begin
            if (m_done) begin
                if (bus.out_ready) m_done = 1'b0;
            end else if (m_busy) begin
                m_cnt++;
                if (m_cnt == K) begin
                    m_busy  = 1'b0;
                    m_done  = 1'b1;
                    m_known = 1'b1;
                end
            end else if (bus.in_valid) begin
`ifdef MPADD_SUB_EN
                m_sub = bus.sub;
`else
                m_sub = 1'b0;
`endif
                m_b     = m_sub ? ~bus.b : bus.b;
                m_cin   = m_sub ? 1'b1 : bus.ci;
                m_res   = {1'b0, bus.a} + {1'b0, m_b} + {{N{1'b0}}, m_cin};
                m_busy  = 1'b1;
                m_cnt   = 0;
                m_known = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic civ,
                          output logic [N-1:0] cv, output logic cov, output int lat);
        int guard;
        bus.a        = av;
        bus.b        = bv;
        bus.ci       = civ;
        bus.in_valid = 1'b1;
        guard        = 0;
        while (!bus.in_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("accept_wait", guard < 20, 1);
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("result_wait", lat < 50, 1);
        cv  = bus.c;
        cov = bus.co;
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] cv;
        logic         cov;
        int           lat;
        logic [N-1:0] ones;
        logic [N-1:0] hold_c;
        logic         hold_co;
        int           acc_cyc[$];

        ones          = '1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.ci        = 1'b0;
        bus.out_ready = 1'b0;
`ifdef MPADD_SUB_EN
        bus.sub       = 1'b0;
`endif

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", {bus.co, bus.c}, 0);
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", bus.in_ready, 1);

        // 1: full-width carry ripple, latency K+1
        run_op(ones, 128'd1, 1'b0, cv, cov, lat);
        check("t1_latency", lat, 5);
        check("t1_sum", {cov, cv}, {1'b1, 128'd0});
        check("t1_model_pin", m_res, {1'b1, 128'd0});
        retire();

        // 2: carry crosses one slice boundary
        run_op(128'h0000_0000_FFFF_FFFF, 128'd1, 1'b0, cv, cov, lat);
        check("t2_latency", lat, 5);
        check("t2_sum", {cov, cv}, {1'b0, 128'h1_0000_0000});
        retire();

        // 3: result held under backpressure while a new request waits
        run_op(128'd3, 128'd4, 1'b1, cv, cov, lat);
        check("t3_sum", {cov, cv}, {1'b0, 128'd8});
        hold_c       = bus.c;
        hold_co      = bus.co;
        bus.a        = 128'hDEAD;
        bus.b        = 128'hBEEF;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", bus.out_valid, 1);
            check("t3_hold_result", {bus.co, bus.c}, {hold_co, hold_c});
            check("t3_hold_in_ready", bus.in_ready, 0);
            tick();
        end
        retire();
        check("t3_ready_after_consume", bus.in_ready, 1);
        bus.in_valid = 1'b0;

        // 4: reset in the middle of RUN aborts the op
        bus.a        = ones;
        bus.b        = ones;
        bus.ci       = 1'b1;
        bus.in_valid = 1'b1;
        check("t4_idle_before", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t4_out_valid", bus.out_valid, 0);
        check("t4_result_cleared", {bus.co, bus.c}, 0);
        check("t4_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_no_result", bus.out_valid, 0);
        end

        // 5: back-to-back random ops, one accept every K+2 cycles
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.a  = {$urandom, $urandom, $urandom, $urandom};
            bus.b  = {$urandom, $urandom, $urandom, $urandom};
            bus.ci = 1'($urandom_range(1));
            if (bus.in_ready) acc_cyc.push_back(cyc);
            tick();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        bus.out_ready = 1'b0;
        check("t5_accept_count", acc_cyc.size() >= 6, 1);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            check("t5_spacing", acc_cyc[i] - acc_cyc[i-1], 6);
        end

`ifdef MPADD_SUB_EN
        // 6: subtraction with and without borrow
        bus.sub = 1'b1;
        run_op(128'd5, 128'd7, 1'b0, cv, cov, lat);
        check("t6_sub_borrow", {cov, cv}, {1'b0, ones - 128'd1});
        retire();
        run_op(128'd7, 128'd5, 1'b1, cv, cov, lat);
        check("t6_sub_no_borrow", {cov, cv}, {1'b1, 128'd2});
        retire();
        bus.sub = 1'b0;
`endif

        for (int i = 0; i < 3; i++) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
